spi_master: RTL and testbench

Single-clock SPI master that issues 10-bit command frames (2-bit opcode + 8-bit payload) to the SPI slave / single-port-RAM subsystem and captures the 8-bit read-back on MISO. Sits between the host-side command interface and the `SS_n`/`MOSI`/`MISO` pins. The SPI link runs on the system clock, with no separate SCLK. The master also enforces read-address/read-data ordering so the slave's internal read sequence stays consistent.

---
 rtl/spi_master.sv | 181 ++++++++++++++++++
 tb/tb_spi_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: single-clock SPI master issuing 10-bit command frames
// ({opcode, payload}) and capturing an 8-bit read-back on MISO.
// Keeps rd-addr/rd-data commands strictly alternating via rd_pend.
module spi_master #(
    parameter int unsigned RD_LAT = 3,
    parameter int unsigned GAP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_word,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       cmd_err,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_START,
        S_SHIFT,
        S_HOLD,
        S_WAIT,
        S_CAPTURE,
        S_GAP
    } state_t;

    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;
    localparam logic [3:0] WAIT_LAST  = 4'(RD_LAT - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [9:0] sreg;
    logic [1:0] op;
    logic       rd_pend;
    logic [6:0] cap;
    logic       accept;
    logic       reject;
    logic       ss_n_d;
    logic       mosi_d;

    assign accept = cmd_valid && (state == S_IDLE);
    assign reject = ((cmd_word[9:8] == OP_RD_ADDR) &&  rd_pend) ||
                    ((cmd_word[9:8] == OP_RD_DATA) && !rd_pend);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: per-state dwell times are measured by cnt
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = reject ? S_ERR : S_START;
                end
            end
            S_ERR: begin
                next_state = S_IDLE;
            end
            S_START: begin
                if (cnt == 4'd1) begin
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == 4'd9) begin
                    next_state = (op == OP_RD_DATA) ? S_WAIT : S_HOLD;
                end
            end
            S_HOLD: begin
                next_state = S_GAP;
            end
            S_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (cnt == 4'd7) begin
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output logic: handshake flags from the current state; pin values are
    // computed from the next state so the SS_n/MOSI flops line up with it
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        cmd_err   = (state == S_ERR);
        ss_n_d    = 1'b1;
        mosi_d    = 1'b0;
        case (next_state)
            S_START, S_SHIFT: begin
                ss_n_d = 1'b0;
                mosi_d = (state == S_IDLE) ? cmd_word[9] : sreg[9];
            end
            S_HOLD, S_WAIT, S_CAPTURE: begin
                ss_n_d = 1'b0;
            end
            default: begin
                ss_n_d = 1'b1;
            end
        endcase
    end

    // Pin registers, dwell counter and command shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n <= 1'b1;
            MOSI <= 1'b0;
            cnt  <= '0;
            sreg <= '0;
            op   <= '0;
        end else begin
            SS_n <= ss_n_d;
            MOSI <= mosi_d;
            if ((next_state != state) || (state == S_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
            if (accept) begin
                sreg <= cmd_word;
                op   <= cmd_word[9:8];
            end else if (next_state == S_SHIFT) begin
                // MOSI already took sreg[9] this edge; expose the next bit
                sreg <= {sreg[8:0], 1'b0};
            end
        end
    end

    // Read capture, read-valid pulse and read-ordering flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            cap      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if ((state == S_HOLD) && (op == OP_RD_ADDR)) begin
                rd_pend <= 1'b1;
            end
            if (state == S_CAPTURE) begin
                cap <= {cap[5:0], MISO};
                if (cnt == 4'd7) begin
                    // rd_data only changes when a whole byte has arrived
                    rd_data  <= {cap, MISO};
                    rd_valid <= 1'b1;
                    rd_pend  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: three spi_master instances (RD_LAT 1, 3, 7; GAP 2) driven
// by one command stream, a behavioural SPI slave/RAM model per instance and
// a command-level reference model of the RAM, ordering flag and read data.
module tb_spi_master;

    localparam int NI = 3;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic [9:0]    cmd_word;
    logic [NI-1:0] cmd_ready;
    logic [NI-1:0] rd_valid;
    logic [NI-1:0] cmd_err;
    logic [NI-1:0] busy;
    logic [NI-1:0] ss_n;
    logic [NI-1:0] mosi;
    logic [NI-1:0] miso;
    logic [7:0]    rd_data [NI];

    logic [7:0]    s_ram   [NI][256];
    logic [7:0]    ref_ram [256];
    logic [7:0]    ref_waddr;
    logic [7:0]    ref_raddr;
    logic          rd_pend;
    logic [7:0]    exp_rd;

    int total = 0;
    int bad   = 0;

    function automatic int lat_of(input int j);
        return (j == 0) ? 1 : ((j == 1) ? 3 : 7);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_master #(
            .RD_LAT (g == 0 ? 1 : (g == 1 ? 3 : 7)),
            .GAP    (2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd_valid (cmd_valid),
            .cmd_ready (cmd_ready[g]),
            .cmd_word  (cmd_word),
            .rd_data   (rd_data[g]),
            .rd_valid  (rd_valid[g]),
            .cmd_err   (cmd_err[g]),
            .busy      (busy[g]),
            .SS_n      (ss_n[g]),
            .MOSI      (mosi[g]),
            .MISO      (miso[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SPI slave: decodes completed frames into its RAM and answers read-data
    // frames RD_LAT cycles after T12, MSB first; MISO is noise otherwise
    initial begin : slave
        int         st    [NI];
        logic [9:0] sw    [NI];
        logic [7:0] waddr [NI];
        logic [7:0] raddr [NI];
        logic [7:0] b;
        int         lat;
        int         idx;
        for (int j = 0; j < NI; j++) begin
            st[j] = 0; sw[j] = '0; waddr[j] = '0; raddr[j] = '0;
            for (int a = 0; a < 256; a++) s_ram[j][a] = '0;
        end
        miso = '0;
        forever begin
            @(negedge clk);
            for (int j = 0; j < NI; j++) begin
                lat = lat_of(j);
                miso[j] = 1'($urandom);
                if (!ss_n[j]) begin
                    if (st[j] >= 2 && st[j] <= 11) sw[j] = {sw[j][8:0], mosi[j]};
                    if (sw[j][9:8] == 2'b11 && st[j] >= 12 + lat && st[j] < 20 + lat) begin
                        b   = s_ram[j][raddr[j]];
                        idx = 7 - (st[j] - 12 - lat);
                        miso[j] = b[idx];
                    end
                    st[j]++;
                end else begin
                    if (st[j] >= 13) begin
                        case (sw[j][9:8])
                            2'b00:   waddr[j] = sw[j][7:0];
                            2'b01:   s_ram[j][waddr[j]] = sw[j][7:0];
                            2'b10:   raddr[j] = sw[j][7:0];
                            default: ;
                        endcase
                    end
                    st[j] = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== '1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(n < 100), 1);
    endtask

    // Issue one command and check the whole frame on every instance
    task automatic send(input logic [9:0] w);
        logic [1:0]  op;
        logic        e;
        int          lenx  [NI];
        int          hi_t  [NI];
        int          rv_t  [NI];
        int          rv_n  [NI];
        int          er_n  [NI];
        int          rdy_t [NI];
        int          bz    [NI];
        logic [11:0] ms    [NI];
        int          maxl;
        op = w[9:8];
        wait_ready();
        e = (op == 2'b10 && rd_pend) || (op == 2'b11 && !rd_pend);
        cmd_word  = w;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_word  = 10'($urandom);
        if (e) begin
            for (int j = 0; j < NI; j++) begin
                chk($sformatf("err_pulse[%0d]", j), cmd_err[j], 1);
                chk($sformatf("err_ssn[%0d]", j), ss_n[j], 1);
            end
            @(negedge clk);
            for (int j = 0; j < NI; j++) begin
                chk($sformatf("err_end[%0d]", j), cmd_err[j], 0);
                chk($sformatf("err_ssn2[%0d]", j), ss_n[j], 1);
                chk($sformatf("err_ready[%0d]", j), cmd_ready[j], 1);
            end
        end else begin
            maxl = 0;
            for (int j = 0; j < NI; j++) begin
                lenx[j] = (op == 2'b11) ? 20 + lat_of(j) : 13;
                if (lenx[j] > maxl) maxl = lenx[j];
                hi_t[j] = -1; rv_t[j] = -1; rv_n[j] = 0; er_n[j] = 0;
                rdy_t[j] = -1; bz[j] = 0; ms[j] = '0;
            end
            for (int t = 0; t <= maxl + 2; t++) begin
                if (t > 0) @(negedge clk);
                if (t == 5) cmd_valid = 1'b1;
                if (t == 8) cmd_valid = 1'b0;
                for (int j = 0; j < NI; j++) begin
                    if (t < 12) ms[j] = {ms[j][10:0], mosi[j]};
                    if (ss_n[j] && hi_t[j] < 0) hi_t[j] = t;
                    if (rd_valid[j]) begin
                        rv_n[j]++;
                        if (rv_t[j] < 0) rv_t[j] = t;
                    end
                    if (cmd_err[j]) er_n[j]++;
                    if (cmd_ready[j] && rdy_t[j] < 0) rdy_t[j] = t;
                    if (busy[j] === cmd_ready[j]) bz[j]++;
                end
            end
            case (op)
                2'b00: ref_waddr = w[7:0];
                2'b01: ref_ram[ref_waddr] = w[7:0];
                2'b10: begin ref_raddr = w[7:0]; rd_pend = 1'b1; end
                default: begin exp_rd = ref_ram[ref_raddr]; rd_pend = 1'b0; end
            endcase
            for (int j = 0; j < NI; j++) begin
                chk($sformatf("mosi_bits[%0d]", j), 32'(ms[j]), 32'({w[9], w[9], w}));
                chk($sformatf("ssn_low_len[%0d]", j), hi_t[j], lenx[j]);
                chk($sformatf("ready_again[%0d]", j), rdy_t[j], lenx[j] + 2);
                chk($sformatf("rd_valid_cnt[%0d]", j), rv_n[j], (op == 2'b11) ? 1 : 0);
                if (op == 2'b11) chk($sformatf("rd_valid_time[%0d]", j), rv_t[j], lenx[j]);
                chk($sformatf("no_err[%0d]", j), er_n[j], 0);
                chk($sformatf("rd_data[%0d]", j), rd_data[j], exp_rd);
                chk($sformatf("busy_vs_ready[%0d]", j), bz[j], 0);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("%s_ssn[%0d]", tag, j), ss_n[j], 1);
            chk($sformatf("%s_mosi[%0d]", tag, j), mosi[j], 0);
            chk($sformatf("%s_ready[%0d]", tag, j), cmd_ready[j], 1);
            chk($sformatf("%s_busy[%0d]", tag, j), busy[j], 0);
            chk($sformatf("%s_rdv[%0d]", tag, j), rd_valid[j], 0);
            chk($sformatf("%s_err[%0d]", tag, j), cmd_err[j], 0);
            chk($sformatf("%s_rdata[%0d]", tag, j), rd_data[j], 0);
        end
    endtask

    initial begin : main
        int  acc;
        int  falls [NI];
        int  hrun  [NI];
        logic prev [NI];
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_word = '0;
        for (int a = 0; a < 256; a++) ref_ram[a] = '0;
        ref_waddr = '0; ref_raddr = '0; rd_pend = 1'b0; exp_rd = '0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_rst");

        // ordering errors
        send({2'b11, 8'h5A});
        send({2'b10, 8'h01});
        send({2'b10, 8'h01});
        send({2'b11, 8'h00});

        // write pair then read back
        send({2'b00, 8'hA5});
        send({2'b01, 8'h3C});
        for (int j = 0; j < NI; j++) chk($sformatf("slave_ram[%0d]", j), s_ram[j][8'hA5], 8'h3C);
        send({2'b10, 8'hA5});
        send({2'b11, 8'h00});

        // 8'h81 read back on every RD_LAT instance
        send({2'b00, 8'h40});
        send({2'b01, 8'h81});
        send({2'b10, 8'h40});
        send({2'b11, 8'h00});

        // reset at T6 of a write frame while a read is pending
        send({2'b10, 8'h22});
        wait_ready();
        cmd_word = {2'b00, 8'hFF}; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("t6_mosi[%0d]", j), mosi[j], 1);
            chk($sformatf("t6_ssn[%0d]", j), ss_n[j], 0);
        end
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("async_ssn[%0d]", j), ss_n[j], 1);
            chk($sformatf("async_mosi[%0d]", j), mosi[j], 0);
        end
        @(negedge clk);
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("rst_rdv[%0d]", j), rd_valid[j], 0);
            chk($sformatf("rst_err[%0d]", j), cmd_err[j], 0);
        end
        rst_n = 1'b1;
        rd_pend = 1'b0; exp_rd = '0;
        @(negedge clk);
        for (int j = 0; j < NI; j++) chk($sformatf("rel_ready[%0d]", j), cmd_ready[j], 1);
        send({2'b10, 8'h33});
        send({2'b11, 8'h00});

        // back-to-back writes with cmd_valid held high
        wait_ready();
        acc = 0;
        for (int j = 0; j < NI; j++) begin falls[j] = 0; hrun[j] = 0; prev[j] = 1'b1; end
        cmd_word = {2'b00, 8'h10}; cmd_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if ((cmd_ready === '1) && cmd_valid) acc++;
            @(negedge clk);
            if (acc >= 3) cmd_valid = 1'b0;
            else cmd_word = {2'b00, 8'(8'h10 + acc)};
            for (int j = 0; j < NI; j++) begin
                if (!ss_n[j] && prev[j]) begin
                    falls[j]++;
                    if (falls[j] > 1) chk($sformatf("b2b_gap[%0d]", j), hrun[j], 3);
                end
                hrun[j] = ss_n[j] ? hrun[j] + 1 : 0;
                prev[j] = ss_n[j];
            end
        end
        cmd_valid = 1'b0;
        ref_waddr = 8'h12;
        for (int j = 0; j < NI; j++) chk($sformatf("b2b_frames[%0d]", j), falls[j], 3);

        // randomized commands
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send({2'($urandom_range(0, 3)), 8'($urandom)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
